// File: rtl/conv_mem_bridge_if.sv
// conv_mem_bridge_if: engine request/response and word-bus signals of the CONV memory bridge
//  slave  : bridge view (takes req_*/bus_rdata/bus_ack, drives req_ready/rsp_*/bus_rd/bus_wstrb/bus_addr/bus_wdata)
//  master : engine + bus view (the opposite directions)
interface conv_mem_bridge_if #(
  parameter int DATA_W = 20,
  parameter int OFFS_W = 12,
  parameter int SEL_W  = 3
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [SEL_W-1:0]  req_sel;
  logic [OFFS_W-1:0] req_offs;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              bus_rd;
  logic [3:0]        bus_wstrb;
  logic [31:0]       bus_addr;
  logic [31:0]       bus_wdata;
  logic [31:0]       bus_rdata;
  logic              bus_ack;
  modport slave (
    input  req_valid, req_we, req_sel, req_offs, req_wdata, bus_rdata, bus_ack,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, bus_rd, bus_wstrb, bus_addr, bus_wdata
  );
  modport master (
    output req_valid, req_we, req_sel, req_offs, req_wdata, bus_rdata, bus_ack,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, bus_rd, bus_wstrb, bus_addr, bus_wdata
  );
endinterface

// File: rtl/conv_mem_bridge.sv
// conv_mem_bridge: registered region/offset -> 32-bit word-bus bridge, one outstanding access, timeout and bad-region errors
//  clk, rst (sync, active-low); io (slave modport): req_* in, req_ready/rsp_* out, bus_* strobes/address/data out, bus_rdata/bus_ack in
module conv_mem_bridge #(
  parameter int          DATA_W      = 20,
  parameter int          OFFS_W      = 12,
  parameter int          NUM_REGIONS = 6,
  parameter int          SEL_W       = 3,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter bit          SIGN_EXT    = 1'b0,
  parameter int          TIMEOUT     = 255
) (
  input logic              clk,
  input logic              rst,
  conv_mem_bridge_if.slave io
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [31:0] HI_MASK = ~32'((64'd1 << DATA_W) - 64'd1);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        err_q, err_d, we_q, we_d;
  logic [31:0] rdata_q, rdata_d, ext_data, addr;
  logic        req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d, bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
  logic        bus_rd_q, bus_rd_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;
  logic        unused_rdata;
  assign unused_rdata = ^io.bus_rdata;
  assign io.req_ready = req_ready_q;
  assign io.rsp_valid = rsp_valid_q;
  assign io.rsp_err   = rsp_err_q;
  assign io.rsp_rdata = rsp_rdata_q;
  assign io.bus_rd    = bus_rd_q;
  assign io.bus_wstrb = bus_wstrb_q;
  assign io.bus_addr  = bus_addr_q;
  assign io.bus_wdata = bus_wdata_q;
  always_comb begin
    ext_data = 32'(io.bus_rdata[DATA_W-1:0]) | ((SIGN_EXT && io.bus_rdata[DATA_W-1]) ? HI_MASK : 32'd0);
    addr = BASE_ADDR + (((32'(io.req_sel) << OFFS_W) + 32'(io.req_offs)) << 2);
    state_d = state_q;
    cnt_d = cnt_q;
    err_d = err_q;
    we_d = we_q;
    rdata_d = rdata_q;
    bus_addr_d = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_rd_d = bus_rd_q;
    bus_wstrb_d = bus_wstrb_q;
    case (state_q)
      IDLE: if (req_ready_q && io.req_valid) begin
        rdata_d = 32'd0;
        if (32'(io.req_sel) < 32'(NUM_REGIONS)) begin
          state_d = BUS;
          cnt_d = '0;
          err_d = 1'b0;
          we_d = io.req_we;
          bus_addr_d = addr;
          bus_wdata_d = 32'(io.req_wdata);
          bus_rd_d = !io.req_we;
          bus_wstrb_d = {4{io.req_we}};
        end else begin
          state_d = RESP;
          err_d = 1'b1;
        end
      end
      BUS: begin
        cnt_d = cnt_q + 1'b1;
        if (io.bus_ack || cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = RESP;
          bus_rd_d = 1'b0;
          bus_wstrb_d = 4'h0;
          err_d = !io.bus_ack;
          rdata_d = (io.bus_ack && !we_q) ? ext_data : 32'd0;
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = state_d == IDLE;
    rsp_valid_d = state_q == RESP;
    rsp_err_d = state_q == RESP && err_q;
    rsp_rdata_d = state_q == RESP ? rdata_q : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      err_q <= 1'b0;
      we_q <= 1'b0;
      rdata_q <= 32'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      bus_rd_q <= 1'b0;
      bus_wstrb_q <= 4'h0;
      bus_addr_q <= 32'd0;
      bus_wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      we_q <= we_d;
      rdata_q <= rdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      bus_rd_q <= bus_rd_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_addr_q <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end
endmodule

// File: tb/tb_conv_mem_bridge.sv
// tb_conv_mem_bridge: directed self-checking bench for conv_mem_bridge (SIGN_EXT=1, TIMEOUT=4)
module tb_conv_mem_bridge;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int fails = 0;
  always #5 clk = ~clk;
  conv_mem_bridge_if #(.DATA_W(20), .OFFS_W(12), .SEL_W(3)) io ();
  conv_mem_bridge #(
    .DATA_W(20), .OFFS_W(12), .NUM_REGIONS(6), .SEL_W(3),
    .BASE_ADDR(32'h0), .SIGN_EXT(1'b1), .TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io(io.slave)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic xfer(input string t, input logic we, input logic [2:0] sel, input logic [11:0] offs,
                      input logic [19:0] wd, input int ack_at, input logic [31:0] rd,
                      input logic [31:0] exp_addr, input logic [31:0] exp_rdata, input logic exp_err,
                      input int exp_strb);
    int n;
    chk({t, ".ready"}, 32'(io.req_ready), 32'd1);
    io.req_valid = 1'b1;
    io.req_we = we;
    io.req_sel = sel;
    io.req_offs = offs;
    io.req_wdata = wd;
    tick();
    io.req_valid = 1'b0;
    chk({t, ".busy"}, 32'(io.req_ready), 32'd0);
    n = 0;
    while ((io.bus_rd || io.bus_wstrb != 4'h0) && n < 20) begin
      if (n == 0) begin
        chk({t, ".addr"}, io.bus_addr, exp_addr);
        chk({t, ".wdata"}, io.bus_wdata, {12'h0, wd});
      end
      chk({t, ".rd"}, 32'(io.bus_rd), 32'(!we));
      chk({t, ".wstrb"}, 32'(io.bus_wstrb), {28'h0, {4{we}}});
      chk({t, ".early_rsp"}, 32'(io.rsp_valid), 32'd0);
      io.bus_ack = (n == ack_at);
      io.bus_rdata = rd;
      tick();
      io.bus_ack = 1'b0;
      n++;
    end
    chk({t, ".strb_cycles"}, 32'(n), 32'(exp_strb));
    chk({t, ".pre_rsp"}, 32'(io.rsp_valid), 32'd0);
    tick();
    chk({t, ".rsp_valid"}, 32'(io.rsp_valid), 32'd1);
    chk({t, ".rsp_err"}, 32'(io.rsp_err), 32'(exp_err));
    chk({t, ".rsp_rdata"}, io.rsp_rdata, exp_rdata);
    chk({t, ".strobes_idle"}, {27'h0, io.bus_rd, io.bus_wstrb}, 32'd0);
    tick();
    chk({t, ".rsp_pulse"}, 32'(io.rsp_valid), 32'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    io.req_valid = 1'b1;
    io.req_we = 1'b0;
    io.req_sel = 3'd1;
    io.req_offs = 12'd5;
    io.req_wdata = 20'h0;
    io.bus_rdata = 32'h0;
    io.bus_ack = 1'b0;
    tick();
    tick();
    chk("rst.ready", 32'(io.req_ready), 32'd0);
    chk("rst.rsp", {29'h0, io.rsp_valid, io.rsp_err, 1'b0}, 32'd0);
    chk("rst.rdata", io.rsp_rdata, 32'd0);
    chk("rst.strobes", {27'h0, io.bus_rd, io.bus_wstrb}, 32'd0);
    chk("rst.addr", io.bus_addr, 32'd0);
    chk("rst.wdata", io.bus_wdata, 32'd0);
    rst = 1'b1;
    io.req_valid = 1'b0;
    tick();
    chk("rst.ready_after", 32'(io.req_ready), 32'd1);
    xfer("rd_neg", 1'b0, 3'd1, 12'd5, 20'h0, 0, 32'hFFF8_0001, 32'h0000_4014, 32'hFFF8_0001, 1'b0, 1);
    xfer("wr_late", 1'b1, 3'd5, 12'hFFF, 20'hABCDE, 3, 32'h0, 32'h0001_7FFC, 32'h0, 1'b0, 4);
    xfer("bad6", 1'b0, 3'd6, 12'd0, 20'h0, -1, 32'h0, 32'h0, 32'h0, 1'b1, 0);
    xfer("bad7", 1'b1, 3'd7, 12'd9, 20'h11111, -1, 32'h0, 32'h0, 32'h0, 1'b1, 0);
    xfer("tmo", 1'b0, 3'd2, 12'd3, 20'h0, -1, 32'hDEAD_BEEF, 32'h0000_800C, 32'h0, 1'b1, 4);
    xfer("rd_pos", 1'b0, 3'd0, 12'hFFF, 20'h0, 2, 32'hFFF7_1234, 32'h0000_3FFC, 32'h0007_1234, 1'b0, 3);
    xfer("wr_ack1", 1'b1, 3'd4, 12'd1, 20'h12345, 1, 32'h0, 32'h0001_0004, 32'h0, 1'b0, 2);
    io.req_valid = 1'b1;
    io.req_we = 1'b0;
    io.req_sel = 3'd3;
    io.req_offs = 12'h010;
    tick();
    io.req_valid = 1'b0;
    chk("abort.rd_on", 32'(io.bus_rd), 32'd1);
    rst = 1'b0;
    tick();
    chk("abort.rd_off", 32'(io.bus_rd), 32'd0);
    chk("abort.no_rsp", 32'(io.rsp_valid), 32'd0);
    rst = 1'b1;
    tick();
    chk("abort.no_rsp2", 32'(io.rsp_valid), 32'd0);
    tick();
    chk("abort.no_rsp3", 32'(io.rsp_valid), 32'd0);
    xfer("post", 1'b0, 3'd3, 12'h010, 20'h0, 0, 32'h0001_2345, 32'h0000_C040, 32'h0001_2345, 1'b0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
